// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt pending controller
// Contents:
//   N_SRC   number of request sources
//   ID_W    width of a source ID
//   irq_state_e  presentation FSM state encoding
package irq_pkg;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned ID_W  = 2;

  // 2'd3 is never entered; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pri_enc.sv
// rtl/irq_pri_enc.sv - 4:2 priority encoder, highest index wins
// Ports:
//   eligible_i  unmasked pending sources
//   enc_o       index of the highest set bit (0 when none set)
//   any_o       at least one bit of eligible_i is set
module irq_pri_enc
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] eligible_i,
  output logic [ID_W-1:0]  enc_o,
  output logic             any_o
);

  always_comb begin
    enc_o = '0;
    any_o = 1'b0;
    casez (eligible_i)
      4'b1???: begin enc_o = 2'd3; any_o = 1'b1; end
      4'b01??: begin enc_o = 2'd2; any_o = 1'b1; end
      4'b001?: begin enc_o = 2'd1; any_o = 1'b1; end
      4'b0001: begin enc_o = 2'd0; any_o = 1'b1; end
      default: begin enc_o = 2'd0; any_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// rtl/irq_pend_ctrl.sv - rising-edge interrupt latch with prioritised valid/ack presentation
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   irq_in     raw request levels (synchronous to clk)
//   irq_mask   1 = source cannot be presented (still latches pending)
//   irq_ack    consumer accepts the presented ID while irq_valid=1
//   irq_valid  an ID is being presented
//   irq_id     presented source ID, stable while irq_valid=1
//   irq_pend   pending register readback
module irq_pend_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pend
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] one_hot_base;
  logic [ID_W-1:0]  enc;
  logic             any;
  logic             accept;

  // prev resets to 0, so a line already high at reset release counts as an edge.
  assign rise = irq_in & ~prev_q;

  // An ack only counts while something is presented.
  assign accept       = (state_q == PRESENT) && irq_ack;
  assign one_hot_base = {{(N_SRC-1){1'b0}}, 1'b1};
  assign clr          = accept ? (one_hot_base << id_q) : '0;

  // Set beats clear: a new edge on the acked source re-pends it.
  assign pend_d = rise | (pend_q & ~clr);

  assign eligible = pend_q & ~irq_mask;

  irq_pri_enc u_pri_enc (
    .eligible_i (eligible),
    .enc_o      (enc),
    .any_o      (any)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (any) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          id_d    = enc;
        end
      end
      PRESENT: begin
        // ID is frozen here; mask changes and new higher edges wait for the next arbitration.
        valid_d = 1'b1;
        if (irq_ack) begin
          state_d = GAP;
          valid_d = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_in;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign irq_pend  = pend_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// tb/tb_irq_pend_ctrl.sv - directed self-checking bench for irq_pend_ctrl
module tb_irq_pend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] irq_pend;

  int n_checks = 0;
  int n_errors = 0;

  irq_pend_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_pend  (irq_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic v, input logic [1:0] id, input logic [3:0] p);
    chk({tag, ".valid"}, {31'd0, irq_valid}, {31'd0, v});
    if (v) chk({tag, ".id"}, {30'd0, irq_id}, {30'd0, id});
    chk({tag, ".pend"}, {28'd0, irq_pend}, {28'd0, p});
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; irq_mask = 4'b0000; irq_ack = 1'b0;
    tick(); tick();
    st("reset", 1'b0, 2'd0, 4'b0000);
    chk("reset.id", {30'd0, irq_id}, 32'd0);
    rst = 1'b0;
    tick();
    st("idle", 1'b0, 2'd0, 4'b0000);

    // single source, basic latency and GAP
    irq_in = 4'b0100;
    tick(); st("t1.pend", 1'b0, 2'd0, 4'b0100);
    tick(); st("t1.pres", 1'b1, 2'd2, 4'b0100);
    irq_ack = 1'b1;
    tick(); st("t1.ack", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0; irq_in = 4'b0000;
    tick(); st("t1.gap", 1'b0, 2'd0, 4'b0000);
    tick(); st("t1.idle", 1'b0, 2'd0, 4'b0000);

    // multiple sources, priority order, no re-arbitration while presenting
    irq_in = 4'b1011;
    tick(); st("t2.pend", 1'b0, 2'd0, 4'b1011);
    irq_in = 4'b0000;
    tick(); st("t2.p3", 1'b1, 2'd3, 4'b1011);
    irq_ack = 1'b1;
    tick(); st("t2.a3", 1'b0, 2'd0, 4'b0011);
    irq_ack = 1'b0;
    tick(); st("t2.gap", 1'b0, 2'd0, 4'b0011);
    tick(); st("t2.p1", 1'b1, 2'd1, 4'b0011);
    irq_in = 4'b1000;
    tick(); st("t3.hold1", 1'b1, 2'd1, 4'b1011);
    tick(); st("t3.hold2", 1'b1, 2'd1, 4'b1011);
    irq_ack = 1'b1;
    tick(); st("t3.a1", 1'b0, 2'd0, 4'b1001);
    irq_ack = 1'b0;
    tick(); st("t3.gap", 1'b0, 2'd0, 4'b1001);
    tick(); st("t3.p3", 1'b1, 2'd3, 4'b1001);
    irq_ack = 1'b1;
    tick(); st("t3.a3", 1'b0, 2'd0, 4'b0001);
    irq_ack = 1'b0;
    tick();
    tick(); st("t2.p0", 1'b1, 2'd0, 4'b0001);
    irq_ack = 1'b1;
    tick(); st("t2.a0", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0; irq_in = 4'b0000;
    tick(); tick();

    // masking
    irq_mask = 4'b1000; irq_in = 4'b1001;
    tick(); st("t4.pend", 1'b0, 2'd0, 4'b1001);
    tick(); st("t4.p0", 1'b1, 2'd0, 4'b1001);
    irq_ack = 1'b1;
    tick(); st("t4.a0", 1'b0, 2'd0, 4'b1000);
    irq_ack = 1'b0;
    tick();
    tick(); st("t4.masked", 1'b0, 2'd0, 4'b1000);
    irq_mask = 4'b0000;
    tick(); st("t4.p3", 1'b1, 2'd3, 4'b1000);
    irq_mask = 4'b1000;
    tick(); st("t4.maskhold", 1'b1, 2'd3, 4'b1000);
    irq_mask = 4'b0000; irq_ack = 1'b1;
    tick(); st("t4.a3", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0; irq_in = 4'b0000;
    tick(); tick();

    // ack coinciding with a new edge on the same source
    irq_in = 4'b0100;
    tick();
    tick(); st("t5.p2", 1'b1, 2'd2, 4'b0100);
    irq_in = 4'b0000;
    tick(); st("t5.hold", 1'b1, 2'd2, 4'b0100);
    irq_ack = 1'b1; irq_in = 4'b0100;
    tick(); st("t5.setwins", 1'b0, 2'd0, 4'b0100);
    irq_ack = 1'b0;
    tick(); st("t5.gap", 1'b0, 2'd0, 4'b0100);
    tick(); st("t5.rep2", 1'b1, 2'd2, 4'b0100);
    irq_ack = 1'b1;
    tick(); st("t5.a2", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0;
    tick(); tick();
    st("t5.level", 1'b0, 2'd0, 4'b0000);

    // ack while idle is ignored
    irq_ack = 1'b1;
    tick(); st("t5.stray1", 1'b0, 2'd0, 4'b0000);
    tick(); st("t5.stray2", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0; irq_in = 4'b0000;
    tick();

    // reset during presentation, line held through release
    irq_in = 4'b0001;
    tick();
    tick(); st("t6.p0", 1'b1, 2'd0, 4'b0001);
    rst = 1'b1; irq_in = 4'b0010; irq_ack = 1'b1;
    tick(); st("t6.rst", 1'b0, 2'd0, 4'b0000);
    chk("t6.rst.id", {30'd0, irq_id}, 32'd0);
    rst = 1'b0; irq_ack = 1'b0;
    tick(); st("t6.pend", 1'b0, 2'd0, 4'b0010);
    tick(); st("t6.p1", 1'b1, 2'd1, 4'b0010);
    irq_ack = 1'b1;
    tick(); st("t6.a1", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0;
    tick(); tick();
    st("t6.level", 1'b0, 2'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
